// File: rtl/mlp_no_sram.sv
// rtl/mlp_no_sram.sv - two-layer MLP inference engine streaming image and weights from external memories
module mlp_no_sram #(
  parameter int DW       = 256,
  parameter int IMG_AW   = 5,
  parameter int WGH_AW   = 10,
  parameter int N_IN     = 784,
  parameter int N_HID    = 30,
  parameter int N_OUT    = 10,
  parameter int L1_SHIFT = 8
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  start_layer1_i,
  input  logic                  start_layer2_i,
  output logic                  weight_bias_mem_req_o,
  input  logic                  weight_bias_mem_ack_i,
  output logic [WGH_AW-1:0]     weight_bias_mem_addr_o,
  output logic                  img_mem_req_o,
  input  logic                  img_mem_ack_i,
  output logic [IMG_AW-1:0]     img_mem_addr_o,
  input  logic [DW-1:0]         image_i,
  input  logic [DW-1:0]         weight_i,
  output logic                  layer1_done_o,
  output logic                  layer2_done_o,
  output logic [16*N_OUT-1:0]   dout_o
);

  localparam int NB         = DW / 8;
  localparam int N_CHUNK    = (N_IN + NB - 1) / NB;
  localparam int LAST_BYTES = N_IN - (N_CHUNK - 1) * NB;
  localparam int CW         = $clog2(N_HID > N_CHUNK ? N_HID : N_CHUNK);

  typedef enum logic [3:0] {
    IDLE, L1_BIAS, L1_FETCH, L1_MAC, L1_DONE, L2_BIAS, L2_FETCH, L2_MAC, L2_DONE
  } state_t;

  state_t             state;
  logic [7:0]         bias  [N_HID];
  logic [7:0]         hid   [N_HID];
  logic [15:0]        score [N_OUT-1];
  logic [DW-1:0]      img_word;
  logic [DW-1:0]      w_word;
  logic signed [31:0] acc;
  logic [CW-1:0]      j_cnt;
  logic [CW-1:0]      k_cnt;
  logic               issued;
  logic               got_img;
  logic               got_w;
  logic               l1_ok;

  logic [DW-1:0]      act_word;
  logic [NB-1:0]      byte_en;
  logic signed [16:0] pa;
  logic signed [16:0] pw;
  logic signed [16:0] prod;
  logic signed [31:0] dot;
  logic signed [31:0] acc_next;
  logic signed [31:0] shifted;
  logic [7:0]         relu_q;
  logic [15:0]        sat_q;

  function automatic logic signed [31:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  // One shared 32-lane dot product; layer 2 reuses it with hidden activations as the unsigned operand.
  always_comb begin
    act_word = '0;
    byte_en  = '0;
    pa       = '0;
    pw       = '0;
    prod     = '0;
    dot      = '0;
    if (state == L1_MAC) begin
      act_word = img_word;
      for (int b = 0; b < NB; b++)
        byte_en[b] = (k_cnt != CW'(N_CHUNK - 1)) || (b < LAST_BYTES);
    end else begin
      for (int b = 0; b < N_HID; b++) begin
        act_word[8*b +: 8] = hid[b];
        byte_en[b]         = 1'b1;
      end
    end
    for (int b = 0; b < NB; b++) begin
      pa   = {9'b0, act_word[8*b +: 8]};
      pw   = {{9{w_word[8*b+7]}}, w_word[8*b +: 8]};
      prod = pa * pw;
      if (byte_en[b])
        dot = dot + {{15{prod[16]}}, prod};
    end
    acc_next = acc + dot;
    shifted  = acc_next >>> L1_SHIFT;
    if (acc_next < 0)
      relu_q = '0;
    else if (shifted > 32'sd255)
      relu_q = 8'hff;
    else
      relu_q = shifted[7:0];
    if (acc_next > 32'sd32767)
      sat_q = 16'h7fff;
    else if (acc_next < -32'sd32768)
      sat_q = 16'h8000;
    else
      sat_q = acc_next[15:0];
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state                  <= IDLE;
      weight_bias_mem_req_o  <= 1'b0;
      weight_bias_mem_addr_o <= '0;
      img_mem_req_o          <= 1'b0;
      img_mem_addr_o         <= '0;
      layer1_done_o          <= 1'b0;
      layer2_done_o          <= 1'b0;
      dout_o                 <= '0;
      for (int i = 0; i < N_HID; i++) begin
        bias[i] <= '0;
        hid[i]  <= '0;
      end
      for (int i = 0; i < N_OUT - 1; i++)
        score[i] <= '0;
      img_word <= '0;
      w_word   <= '0;
      acc      <= '0;
      j_cnt    <= '0;
      k_cnt    <= '0;
      issued   <= 1'b0;
      got_img  <= 1'b0;
      got_w    <= 1'b0;
      l1_ok    <= 1'b0;
    end else begin
      layer1_done_o <= 1'b0;
      layer2_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_layer1_i) begin
            state                  <= L1_BIAS;
            l1_ok                  <= 1'b0;
            weight_bias_mem_req_o  <= 1'b1;
            weight_bias_mem_addr_o <= '0;
          end else if (start_layer2_i && l1_ok) begin
            state                  <= L2_BIAS;
            weight_bias_mem_req_o  <= 1'b1;
            weight_bias_mem_addr_o <= '0;
          end
        end
        L1_BIAS, L2_BIAS: begin
          if (weight_bias_mem_req_o && weight_bias_mem_ack_i) begin
            for (int b = 0; b < N_HID; b++)
              bias[b] <= weight_i[8*b +: 8];
            acc                    <= sext8(weight_i[7:0]);
            weight_bias_mem_req_o  <= 1'b0;
            weight_bias_mem_addr_o <= WGH_AW'(1);
            img_mem_addr_o         <= '0;
            j_cnt                  <= '0;
            k_cnt                  <= '0;
            issued                 <= 1'b0;
            state                  <= (state == L1_BIAS) ? L1_FETCH : L2_FETCH;
          end
        end
        L1_FETCH, L2_FETCH: begin
          // First cycle raises the requests; later cycles collect acks, which may arrive in any order.
          if (!issued) begin
            issued                <= 1'b1;
            weight_bias_mem_req_o <= 1'b1;
            img_mem_req_o         <= (state == L1_FETCH);
            got_w                 <= 1'b0;
            got_img               <= (state == L2_FETCH);
          end else begin
            if (weight_bias_mem_req_o && weight_bias_mem_ack_i) begin
              w_word                <= weight_i;
              weight_bias_mem_req_o <= 1'b0;
              got_w                 <= 1'b1;
            end
            if (img_mem_req_o && img_mem_ack_i) begin
              img_word      <= image_i;
              img_mem_req_o <= 1'b0;
              got_img       <= 1'b1;
            end
            if (got_w && got_img) begin
              issued <= 1'b0;
              state  <= (state == L1_FETCH) ? L1_MAC : L2_MAC;
            end
          end
        end
        L1_MAC: begin
          weight_bias_mem_addr_o <= weight_bias_mem_addr_o + 1'b1;
          state                  <= L1_FETCH;
          if (k_cnt == CW'(N_CHUNK - 1)) begin
            hid[j_cnt]     <= relu_q;
            k_cnt          <= '0;
            img_mem_addr_o <= '0;
            if (j_cnt == CW'(N_HID - 1)) begin
              layer1_done_o <= 1'b1;
              l1_ok         <= 1'b1;
              state         <= L1_DONE;
            end else begin
              acc   <= sext8(bias[j_cnt + 1'b1]);
              j_cnt <= j_cnt + 1'b1;
            end
          end else begin
            acc            <= acc_next;
            k_cnt          <= k_cnt + 1'b1;
            img_mem_addr_o <= img_mem_addr_o + 1'b1;
          end
        end
        L2_MAC: begin
          if (j_cnt == CW'(N_OUT - 1)) begin
            for (int i = 0; i < N_OUT - 1; i++)
              dout_o[16*i +: 16] <= score[i];
            dout_o[16*(N_OUT-1) +: 16] <= sat_q;
            layer2_done_o <= 1'b1;
            state         <= L2_DONE;
          end else begin
            score[j_cnt]           <= sat_q;
            acc                    <= sext8(bias[j_cnt + 1'b1]);
            j_cnt                  <= j_cnt + 1'b1;
            weight_bias_mem_addr_o <= weight_bias_mem_addr_o + 1'b1;
            state                  <= L2_FETCH;
          end
        end
        L1_DONE, L2_DONE: state <= IDLE;
        default:          state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_no_sram.sv
// tb/tb_mlp_no_sram.sv - directed self-checking bench for mlp_no_sram
module tb_mlp_no_sram;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         start1;
  logic         start2;
  logic         w_req;
  logic         w_ack;
  logic [9:0]   w_addr;
  logic         img_req;
  logic         img_ack;
  logic [4:0]   img_addr;
  logic [255:0] image;
  logic [255:0] weight;
  logic         l1_done;
  logic         l2_done;
  logic [159:0] dout;

  always #5 clk = ~clk;

  mlp_no_sram dut (
    .clk                    (clk),
    .rst_b                  (rst_b),
    .start_layer1_i         (start1),
    .start_layer2_i         (start2),
    .weight_bias_mem_req_o  (w_req),
    .weight_bias_mem_ack_i  (w_ack),
    .weight_bias_mem_addr_o (w_addr),
    .img_mem_req_o          (img_req),
    .img_mem_ack_i          (img_ack),
    .img_mem_addr_o         (img_addr),
    .image_i                (image),
    .weight_i               (weight),
    .layer1_done_o          (l1_done),
    .layer2_done_o          (l2_done),
    .dout_o                 (dout)
  );

  logic [255:0] wmem [0:750];
  logic [255:0] imem [0:24];
  int           lat     = 1;
  int           hs_viol = 0;
  int           l1_cnt  = 0;
  int           l2_cnt  = 0;
  int           w_cnt   = 0;
  int           i_cnt   = 0;
  logic [9:0]   w_hold;
  logic [4:0]   i_hold;
  int           w_log [$];
  int           i_log [$];
  int           checks  = 0;
  int           errors  = 0;

  // Memory responders: ack after lat cycles, flag unstable address/req or req held past ack.
  always @(negedge clk) begin
    if (!rst_b) begin
      w_ack = 1'b0; w_cnt = 0; weight = '0;
    end else if (w_ack) begin
      w_ack = 1'b0; w_cnt = 0;
      if (w_req) hs_viol++;
    end else if (w_req) begin
      if (w_cnt == 0) w_hold = w_addr;
      else if (w_addr != w_hold) hs_viol++;
      w_cnt++;
      if (w_cnt >= lat) begin
        w_ack  = 1'b1;
        weight = (w_addr <= 10'd750) ? wmem[w_addr] : '0;
        w_log.push_back(int'(w_addr));
      end
    end else if (w_cnt != 0) begin
      hs_viol++; w_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      img_ack = 1'b0; i_cnt = 0; image = '0;
    end else if (img_ack) begin
      img_ack = 1'b0; i_cnt = 0;
      if (img_req) hs_viol++;
    end else if (img_req) begin
      if (i_cnt == 0) i_hold = img_addr;
      else if (img_addr != i_hold) hs_viol++;
      i_cnt++;
      if (i_cnt >= lat) begin
        img_ack = 1'b1;
        image   = (img_addr <= 5'd24) ? imem[img_addr] : '0;
        i_log.push_back(int'(img_addr));
      end
    end else if (i_cnt != 0) begin
      hs_viol++; i_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (l1_done) l1_cnt++;
    if (l2_done) l2_cnt++;
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic s1, input logic s2);
    @(negedge clk); start1 = s1; start2 = s2;
    @(negedge clk); start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic run_l1(input string tag, input logic spurious);
    int base, n;
    base = l1_cnt;
    w_log.delete(); i_log.delete();
    pulse(1'b1, 1'b0);
    if (spurious) begin
      repeat (40) @(negedge clk);
      pulse(1'b1, 1'b0); pulse(1'b0, 1'b1); pulse(1'b1, 1'b1);
    end
    n = 0;
    while (l1_cnt == base && n < 20000) begin @(negedge clk); n++; end
    check({tag, "_l1_timeout"}, n < 20000, 1'b1);
    repeat (3) @(negedge clk);
    check({tag, "_l1_pulses"}, l1_cnt - base, 1);
  endtask

  task automatic run_l2(input string tag);
    int base, n;
    base = l2_cnt;
    w_log.delete();
    pulse(1'b0, 1'b1);
    n = 0;
    while (l2_cnt == base && n < 2000) begin @(negedge clk); n++; end
    check({tag, "_l2_timeout"}, n < 2000, 1'b1);
    repeat (3) @(negedge clk);
    check({tag, "_l2_pulses"}, l2_cnt - base, 1);
  endtask

  task automatic load_l1(input logic [7:0] pix, input logic [7:0] bv, input logic [7:0] wv);
    for (int k = 0; k < 25; k++) imem[k] = {32{pix}};
    wmem[0] = {32{bv}};
    for (int a = 1; a <= 750; a++) wmem[a] = {32{wv}};
  endtask

  task automatic load_l2(input logic [7:0] wv, input int b0, input int bstep);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < 10; i++) w[8*i +: 8] = 8'(b0 + i * bstep);
    wmem[0] = w;
    for (int a = 1; a <= 10; a++) wmem[a] = {32{wv}};
  endtask

  // Neuron j: bias j, weights j; image all 1 except masked tail of word 24 holds 200.
  task automatic load_d_l1();
    logic [255:0] w;
    for (int k = 0; k < 25; k++) imem[k] = {32{8'd1}};
    imem[24][255:128] = {16{8'd200}};
    w = '0;
    for (int j = 0; j < 30; j++) w[8*j +: 8] = 8'(j);
    wmem[0] = w;
    for (int j = 0; j < 30; j++)
      for (int k = 0; k < 25; k++) wmem[25*j + k + 1] = {32{8'(j)}};
  endtask

  // Output i picks h[3i] with weight 1, bias 10; bytes 30..31 carry junk.
  task automatic load_d_l2();
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < 10; i++) w[8*i +: 8] = 8'd10;
    wmem[0] = w;
    for (int i = 0; i < 10; i++) begin
      w = '0;
      w[8*(3*i) +: 8] = 8'd1;
      w[255:240] = 16'h5555;
      wmem[i + 1] = w;
    end
  endtask

  initial begin
    int bad;
    logic [159:0] exp;
    logic [159:0] exp_d;
    int d_tab [10];
    d_tab = '{10, 19, 28, 37, 46, 55, 65, 74, 83, 92};
    exp_d = '0;
    for (int i = 0; i < 10; i++) exp_d[16*i +: 16] = 16'(d_tab[i]);

    rst_b = 1'b0; start1 = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (w_req || img_req || l1_done || l2_done || dout != '0 || w_addr != '0 || img_addr != '0) bad++;
    end
    check("idle_outputs", bad, 0);
    check("reset_dout", dout, '0);

    pulse(1'b0, 1'b1);
    bad = 0;
    repeat (10) begin @(negedge clk); if (w_req || img_req) bad++; end
    check("early_l2_ignored", bad, 0);

    // A: pixels 2, weights 1 -> h = 6; layer 2 weights 1, bias 5 -> 185
    load_l1(8'd2, 8'd0, 8'd1);
    run_l1("a", 1'b0);
    check("a_wlog_len", w_log.size(), 751);
    bad = 0;
    foreach (w_log[i]) if (w_log[i] != i) bad++;
    check("a_waddr_seq", bad, 0);
    check("a_ilog_len", i_log.size(), 750);
    bad = 0;
    foreach (i_log[i]) if (i_log[i] != i % 25) bad++;
    check("a_iaddr_seq", bad, 0);
    load_l2(8'd1, 5, 0);
    run_l2("a");
    check("a_scores", dout, {10{16'h00b9}});
    bad = 0;
    foreach (w_log[i]) if (w_log[i] != i) bad++;
    check("a_l2_addr_seq", bad + (w_log.size() != 11 ? 1 : 0), 0);

    // B: h = 255 everywhere; saturate both ways, second layer 2 without a new layer 1
    load_l1(8'd255, 8'd0, 8'd127);
    run_l1("b", 1'b0);
    load_l2(8'h80, 0, 0);
    run_l2("b_neg");
    check("b_sat_neg", dout, {10{16'h8000}});
    load_l2(8'd127, 0, 0);
    run_l2("b_pos");
    check("b_sat_pos", dout, {10{16'h7fff}});

    // C: negative layer-1 weights -> h = 0, score = bias2 = 5i-20
    load_l1(8'd255, 8'd127, 8'hff);
    run_l1("c", 1'b0);
    load_l2(8'd127, -20, 5);
    run_l2("c");
    exp = '0;
    for (int i = 0; i < 10; i++) exp[16*i +: 16] = 16'(i * 5 - 20);
    check("c_relu_bias", dout, exp);

    // D: per-neuron values and chunk-24 masking, 1-cycle memory
    load_d_l1();
    run_l1("d", 1'b0);
    load_d_l2();
    run_l2("d");
    check("d_scores", dout, exp_d);

    // D again with 5-cycle ack latency
    lat = 5;
    load_d_l1();
    run_l1("stall", 1'b0);
    load_d_l2();
    run_l2("stall");
    check("stall_scores", dout, exp_d);
    lat = 1;

    // Reset in the middle of layer 1, then restart with spurious starts while busy
    load_d_l1();
    pulse(1'b1, 1'b0);
    repeat (300) @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("rst_req", {w_req, img_req}, 2'b00);
    check("rst_addr", {w_addr, img_addr}, 15'd0);
    check("rst_dout", dout, '0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    pulse(1'b0, 1'b1);
    bad = 0;
    repeat (10) begin @(negedge clk); if (w_req || img_req) bad++; end
    check("abort_l2_ignored", bad, 0);
    run_l1("restart", 1'b1);
    check("restart_wlog_len", w_log.size(), 751);
    load_d_l2();
    run_l2("restart");
    check("restart_scores", dout, exp_d);

    check("handshake", hs_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mlp_no_sram.md
Name: mlp_no_sram

Overview:
- Two-layer MLP inference engine for 28x28 digit images: 784 inputs, 30 hidden neurons with ReLU, 10 outputs.
- Holds no image or weight storage. It fetches 256-bit words from an external image memory and an external weight/bias memory over req/ack handshakes.
- Hidden activations are kept internally. The 10 output scores go to the host, which picks the argmax.
- The host reloads the weight memory with layer-2 contents between layer1_done_o and start_layer2_i.

Parameters:
- DW, 256, memory word width (32 bytes per word).
- IMG_AW, 5, image memory address width.
- WGH_AW, 10, weight memory address width.
- N_IN, 784, layer-1 inputs (25 words; last word has 16 valid bytes).
- N_HID, 30, hidden neurons.
- N_OUT, 10, outputs.
- L1_SHIFT, 8, right shift applied to layer-1 accumulators before clamping.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- start_layer1_i  in  1  one-cycle pulse, starts layer 1.
- start_layer2_i  in  1  one-cycle pulse, starts layer 2.
- weight_bias_mem_req_o  out  1  weight memory read request.
- weight_bias_mem_ack_i  in  1  weight_i valid this cycle.
- weight_bias_mem_addr_o  out  WGH_AW  weight word address.
- img_mem_req_o  out  1  image memory read request.
- img_mem_ack_i  in  1  image_i valid this cycle.
- img_mem_addr_o  out  IMG_AW  image word address.
- image_i  in  DW  image word; byte b is bits [8b+7:8b].
- weight_i  in  DW  weight/bias word, same byte order.
- layer1_done_o  out  1  one-cycle pulse, layer 1 complete.
- layer2_done_o  out  1  one-cycle pulse, layer 2 complete.
- dout_o  out  160  10 signed 16-bit scores; score i is bits [16i+15:16i].

Behaviour:
- Single clock; asynchronous active-low reset on rst_b.
- Reset state: all req outputs 0, addresses 0, done pulses 0, dout_o 0, hidden registers 0, FSM IDLE. Reset mid-operation aborts immediately to these values.

Data formats:
- Pixels are unsigned 8-bit.
- Weights and biases are signed 8-bit.
- Hidden activations are unsigned 8-bit.

Memory maps:
- Layer-1 weight memory: word 0 holds bias1 in bytes 0..29; word 25j+k+1 holds weights of neuron j for pixels 32k..32k+31. Address range is 1..750.
- Image memory: word k holds pixels 32k..32k+31, k = 0..24.
- Layer-2 weight memory: word 0 holds bias2 in bytes 0..9; word j+1 holds weights of output j in bytes 0..29.

Handshake:
- Assert req with a stable address until ack is seen. rdata is sampled on the ack cycle.
- Drop req in the cycle after ack. Tolerate any ack latency of at least 1 cycle.
- Image and weight requests may be outstanding simultaneously. Proceed only when both required acks have been captured.

FSM states: IDLE -> L1_BIAS -> L1_FETCH <-> L1_MAC -> L1_DONE -> IDLE(L2_WAIT) -> L2_BIAS -> L2_FETCH <-> L2_MAC -> L2_DONE -> IDLE.
- start_layer1_i is accepted only in IDLE. start_layer2_i is accepted only in IDLE after a completed layer 1.
- All starts outside those conditions are ignored. If both starts arrive in the same cycle, layer 1 wins.

Layer 1:
- Read word 0 and latch the 30 biases.
- For each neuron j = 0..29 and chunk k = 0..24, fetch image word k and weight word 25j+k+1.
- MAC: acc += sum over valid bytes b of pixel*weight, using 32 parallel 8x8 signed multiplies (pixel zero-extended).
- Chunk 24 masks bytes 16..31 to zero. acc is signed 32-bit and is initialised to the sign-extended bias.
- After chunk 24: h[j] = clamp(max(acc,0) >>> L1_SHIFT, 0, 255).
- After neuron 29: pulse layer1_done_o for 1 cycle.

Layer 2:
- Read word 0 and latch bias2.
- For j = 0..9, fetch word j+1. acc = bias + sum over b = 0..29 of h[b]*w[b]; bytes 30..31 are masked.
- Score j = saturate(acc) to the signed 16-bit range [-32768, 32767].
- After output 9: update all of dout_o together and pulse layer2_done_o.
- dout_o holds its value until the next layer2_done_o or reset.

Test Plan:
- Reset, no starts: all outputs 0 for 100 cycles; no req asserted.
- Layer 1 address sequence: pulse start_layer1_i with a 1-cycle-latency memory. Weight addresses must be 0, then 1..25 while image addresses go 0..24, repeating through weight address 750. Exactly one layer1_done_o pulse follows.
- Layer 1 arithmetic: all pixels 2, all weights 1, bias1 = 0. Each hidden acc = 1568, so h = 6. Layer 2 with weights 1 and bias2 = 5 gives every score 185 = 0x00B9; layer2_done_o pulses once.
- Saturation and ReLU: all pixels 255, weights 127, so h = 255. Layer 2 weights -128 give score -979200, saturated to 0x8000. Negative layer-1 weights give h = 0, so the score equals bias2.
- Handshake stall: ack delayed 5 cycles. req and addr stay stable throughout, and results match the 1-cycle-latency case.
- Reset mid-layer-1: drop rst_b, then restart. The run completes normally; spurious starts issued while busy are ignored.
